instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Program-counter sequencer that drives the address port of the instruction memory and consumes its registered instruction/valid outputs. It presents fetched instructions, each tagged with its PC, to the decoder over a valid/ready handshake. A zero instruction (memory valid = 0) marks end of program. Sits between instruction memory and the decode/dispatch stage.

Parameters:
INSTR_WIDTH, 32, instruction word width
INSTR_MEM_ADDR_WIDTH, 10, instruction memory address width
START_ADDR, 0, PC loaded on start

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse; begin fetching at START_ADDR
imem_address  out  INSTR_MEM_ADDR_WIDTH  address to instruction memory
imem_instr  in  INSTR_WIDTH  memory data; returned 1 cycle after address is sampled
imem_valid  in  1  memory valid; 0 = end of program
instr_out  out  INSTR_WIDTH  fetched instruction to decoder
instr_pc  out  INSTR_MEM_ADDR_WIDTH  PC of instr_out
instr_valid_out  out  1  instr_out/instr_pc valid
instr_ready  in  1  decoder accepts when valid && ready
busy  out  1  high in FETCH and DRAIN
done  out  1  one-cycle pulse at program end
halt_pc  out  INSTR_MEM_ADDR_WIDTH  address of terminating instruction

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-high.
- Reset values: imem_address = START_ADDR; instr_out = 0; instr_pc = 0; instr_valid_out = 0; busy = 0; done = 0; halt_pc = 0. FIFO is emptied and the pending flag is cleared.
- Memory contract:
  - imem_address is driven from pc_q.
  - Address A presented in cycle t gives data in cycle t+1.
  - A registered pending flag, with its tag pc, marks whether the cycle t+1 data belongs to a real request. Untagged memory output is ignored, including memory reset garbage.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE: start=1 loads pc_q = START_ADDR and moves to FETCH. start is ignored in every other state.
  - FETCH: issue request at pc_q when fifo_count + pending - pop < 2, where pop = instr_valid_out && instr_ready. On issue, pending is set and pc_q increments modulo 2^INSTR_MEM_ADDR_WIDTH (1023 wraps to 0).
  - FETCH responses: pending with imem_valid=1 pushes {imem_instr, tag} into the FIFO. pending with imem_valid=0 is not pushed; it sets halt_pc = tag, inhibits issue in that same cycle, and moves to DRAIN.
  - DRAIN: no issue. Any response still in flight is discarded. When the FIFO is empty, move to DONE.
  - DONE: done=1 for one cycle, then IDLE. halt_pc is held until the next start.
- Buffer: 2-entry FIFO. Head drives instr_out, instr_pc and instr_valid_out.
  - Outputs are stable while valid && !ready.
  - Push and pop in the same cycle are allowed.
  - Never overflows; guaranteed by the issue rule.
- Throughput: 1 instr/cycle with instr_ready held high. First instr_valid_out appears 3 cycles after the start pulse: start, issue, response, then visible from the FIFO.
- rst mid-operation: immediate return to reset values. In-flight data is dropped.

Optional Feature:
IFU_PERF_CNT_EN
- Defined: adds outputs perf_fetched (32b) and perf_stall (32b).
  - perf_fetched counts handshakes.
  - perf_stall counts cycles with instr_valid_out && !instr_ready.
  - Both saturate at all-ones, clear on rst and on start.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package tsp_fetch_pkg:
  - fetch_state_t enum {IDLE, FETCH, DRAIN, DONE}
  - FETCH_FIFO_DEPTH = 2
  - fetch_entry_t struct {instr, pc}
- Sub-module fetch_skid_fifo: 2-entry, parameterised on entry type width. Provides push, pop, count, head.

Test Plan:
- mem[0..2] = 0x03002080, 0x04000810, 0x0, ready=1, start -> instr_out 0x03002080 @pc 0 then 0x04000810 @pc 1 on consecutive cycles; done pulse; halt_pc = 2; busy low afterwards.
- Same program, ready=0 for 5 cycles after first valid -> instr_out holds 0x03002080 with pc 0; imem_address advances at most 2 beyond the head; no instruction lost or duplicated after ready=1.
- START_ADDR = 1022; mem[1022], mem[1023], mem[0] nonzero; mem[1] = 0 -> pcs 1022, 1023, 0 delivered; halt_pc = 1.
- mem[0] = 0, start -> no instr_valid_out; done pulse within 4 cycles of start; halt_pc = 0.
- Assert rst mid-FETCH with FIFO holding 2 entries -> next cycle all outputs at reset values; start after rst deasserts refetches from pc 0.
- start pulsed during FETCH -> ignored, sequence unchanged. With IFU_PERF_CNT_EN: first scenario gives perf_fetched = 2, perf_stall = 0.

Source files
------------

// File: rtl/tsp_fetch_pkg.sv
// Shared fetch-unit types: FSM encoding, skid FIFO depth, fetch entry layout
// and the FIFO occupancy update helper.
package tsp_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

   localparam int FETCH_FIFO_DEPTH = 2;
   localparam int FETCH_INSTR_W    = 32;
   localparam int FETCH_ADDR_W     = 10;

   typedef struct packed {
      logic [FETCH_INSTR_W-1:0] instr;
      logic [FETCH_ADDR_W-1:0]  pc;
   } fetch_entry_t;

   function automatic logic [1:0] fifo_count_next(input logic [1:0] count,
                                                  input logic       push,
                                                  input logic       pop);
      return count + {1'b0, push} - {1'b0, pop};
   endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO between the memory response path and the decoder
// handshake; the head is visible combinationally from the storage registers.
module fetch_skid_fifo
   import tsp_fetch_pkg::*;
#(
   parameter int WIDTH = FETCH_INSTR_W + FETCH_ADDR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [1:0]       count_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] slot0_q, slot0_d;
   logic [WIDTH-1:0] slot1_q, slot1_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   // Next-state for storage, pointers and occupancy
   always_comb begin
      slot0_d   = slot0_q;
      slot1_d   = slot1_q;
      do_pop_s  = pop_i && (count_q != 2'd0);
      // A full FIFO only accepts a push when the head leaves in the same cycle
      do_push_s = push_i && ((count_q != 2'(FETCH_FIFO_DEPTH)) || do_pop_s);
      if (do_push_s) begin
         if (wr_ptr_q == 1'b0) begin
            slot0_d = data_i;
         end else begin
            slot1_d = data_i;
         end
         wr_ptr_d = ~wr_ptr_q;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = fifo_count_next(count_q, do_push_s, do_pop_s);
   end

   // Storage and pointer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         slot0_q  <= {WIDTH{1'b0}};
         slot1_q  <= {WIDTH{1'b0}};
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         slot0_q  <= slot0_d;
         slot1_q  <= slot1_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = rd_ptr_q ? slot1_q : slot0_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC sequencer feeding the decoder from a one-cycle-latency instruction memory.
// Optional build macro IFU_PERF_CNT_EN adds handshake/stall counters.
module instruction_fetch_unit
   import tsp_fetch_pkg::*;
#(
   parameter int INSTR_WIDTH          = 32,
   parameter int INSTR_MEM_ADDR_WIDTH = 10,
   parameter int START_ADDR           = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   output logic [INSTR_MEM_ADDR_WIDTH-1:0] imem_address,
   input  logic [INSTR_WIDTH-1:0]          imem_instr,
   input  logic                            imem_valid,
   output logic [INSTR_WIDTH-1:0]          instr_out,
   output logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_pc,
   output logic                            instr_valid_out,
   input  logic                            instr_ready,
   output logic                            busy,
   output logic                            done,
   output logic [INSTR_MEM_ADDR_WIDTH-1:0] halt_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]                     perf_fetched,
   output logic [31:0]                     perf_stall
`endif
);

   localparam int AW      = INSTR_MEM_ADDR_WIDTH;
   localparam int ENTRY_W = INSTR_WIDTH + AW;
   localparam logic [AW-1:0] START_PC = AW'(START_ADDR);
   localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};

   fetch_state_t       state_q, state_d;
   logic [AW-1:0]      pc_q, pc_d;
   logic               pending_q, pending_d;
   logic [AW-1:0]      tag_q, tag_d;
   logic [AW-1:0]      halt_pc_q, halt_pc_d;

   logic               start_acc_s;
   logic               pop_s;
   logic               resp_s;
   logic               push_s;
   logic               halt_s;
   logic               issue_s;
   logic [2:0]         occ_s;
   logic [1:0]         fifo_count_s;
   logic [ENTRY_W-1:0] fifo_head_s;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            if (halt_s) begin
               state_d = DRAIN;
            end else begin
               state_d = FETCH;
            end
         end
         DRAIN: begin
            if (fifo_count_s == 2'd0) begin
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         FETCH:   busy = 1'b1;
         DRAIN:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // Issue, response and halt decisions
   always_comb begin
      start_acc_s = (state_q == IDLE) && start;
      pop_s       = instr_valid_out && instr_ready;
      // Only responses tagged by a FETCH-state issue are consumed
      resp_s      = (state_q == FETCH) && pending_q;
      push_s      = resp_s && imem_valid;
      halt_s      = resp_s && !imem_valid;
      occ_s       = {1'b0, fifo_count_s} + {2'b00, pending_q} - {2'b00, pop_s};
      issue_s     = (state_q == FETCH) && !halt_s && (occ_s < 3'(FETCH_FIFO_DEPTH));
      pending_d   = issue_s;
      if (start_acc_s) begin
         pc_d = START_PC;
      end else if (issue_s) begin
         pc_d = pc_q + PC_ONE;
      end else begin
         pc_d = pc_q;
      end
      if (issue_s) begin
         tag_d = pc_q;
      end else begin
         tag_d = tag_q;
      end
      if (start_acc_s) begin
         halt_pc_d = {AW{1'b0}};
      end else if (halt_s) begin
         halt_pc_d = tag_q;
      end else begin
         halt_pc_d = halt_pc_q;
      end
   end

   // PC, pending tag and halt address registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= START_PC;
         pending_q <= 1'b0;
         tag_q     <= {AW{1'b0}};
         halt_pc_q <= {AW{1'b0}};
      end else begin
         pc_q      <= pc_d;
         pending_q <= pending_d;
         tag_q     <= tag_d;
         halt_pc_q <= halt_pc_d;
      end
   end

   fetch_skid_fifo #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s),
      .data_i  ({imem_instr, tag_q}),
      .pop_i   (pop_s),
      .count_o (fifo_count_s),
      .head_o  (fifo_head_s)
   );

   assign imem_address            = pc_q;
   assign halt_pc                 = halt_pc_q;
   assign instr_valid_out         = (fifo_count_s != 2'd0);
   assign {instr_out, instr_pc}   = fifo_head_s;

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_stall_q;

   // Saturating handshake and back-pressure counters, cleared by an accepted start
   always_ff @(posedge clk) begin
      if (rst || start_acc_s) begin
         perf_fetched_q <= 32'd0;
         perf_stall_q   <= 32'd0;
      end else begin
         if (pop_s && (perf_fetched_q != 32'hFFFF_FFFF)) begin
            perf_fetched_q <= perf_fetched_q + 32'd1;
         end
         if (instr_valid_out && !instr_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table, random programs
// against a program-walk model, and hand-written reset sequences.
module tb_instruction_fetch_unit;

   localparam int IW    = 32;
   localparam int AW    = 10;
   localparam int MEM_N = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start0, start1, ready, sel;
   logic [AW-1:0] addr0, addr1, pc0, pc1, halt0, halt1;
   logic [IW-1:0] mi0, mi1, io0, io1;
   logic          mv0, mv1, v0, v1, busy0, busy1, done0, done1;
   logic [IW-1:0] mem [MEM_N];
`ifdef IFU_PERF_CNT_EN
   logic [31:0]   pf0, ps0, pf1, ps1;
`endif

   instruction_fetch_unit #(.INSTR_WIDTH(IW), .INSTR_MEM_ADDR_WIDTH(AW), .START_ADDR(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .imem_address(addr0), .imem_instr(mi0),
      .imem_valid(mv0), .instr_out(io0), .instr_pc(pc0), .instr_valid_out(v0),
      .instr_ready(ready), .busy(busy0), .done(done0), .halt_pc(halt0)
`ifdef IFU_PERF_CNT_EN
      , .perf_fetched(pf0), .perf_stall(ps0)
`endif
   );

   instruction_fetch_unit #(.INSTR_WIDTH(IW), .INSTR_MEM_ADDR_WIDTH(AW), .START_ADDR(1022)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .imem_address(addr1), .imem_instr(mi1),
      .imem_valid(mv1), .instr_out(io1), .instr_pc(pc1), .instr_valid_out(v1),
      .instr_ready(ready), .busy(busy1), .done(done1), .halt_pc(halt1)
`ifdef IFU_PERF_CNT_EN
      , .perf_fetched(pf1), .perf_stall(ps1)
`endif
   );

   // Registered-read instruction memory, one port per DUT
   always @(posedge clk) begin
      mi0 <= mem[addr0];
      mv0 <= (mem[addr0] != 32'd0);
      mi1 <= mem[addr1];
      mv1 <= (mem[addr1] != 32'd0);
   end

   logic [AW-1:0] m_addr, m_pc, m_halt;
   logic [IW-1:0] m_out;
   logic          m_valid, m_busy, m_done;
   assign m_addr  = sel ? addr1 : addr0;
   assign m_pc    = sel ? pc1   : pc0;
   assign m_halt  = sel ? halt1 : halt0;
   assign m_out   = sel ? io1   : io0;
   assign m_valid = sel ? v1    : v0;
   assign m_busy  = sel ? busy1 : busy0;
   assign m_done  = sel ? done1 : done0;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] m_pf, m_ps;
   assign m_pf = sel ? pf1 : pf0;
   assign m_ps = sel ? ps1 : ps0;
`endif

   int checks = 0;
   int errors = 0;

   logic [IW-1:0] exp_instr [$];
   int            exp_pc    [$];

   typedef struct {
      logic sel;
      int   len;
      int   mode;      // 0 ready high, 1 five-cycle stall at first valid, 2 random ready
      logic fixed;
      logic xstart;
      int   exp_n;
      int   exp_halt;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " addr0"}, 32'(addr0), 32'd0);
      chk({tag, " addr1"}, 32'(addr1), 32'd1022);
      chk({tag, " instr_out"}, io0, 32'd0);
      chk({tag, " instr_pc"}, 32'(pc0), 32'd0);
      chk({tag, " valid"}, 32'(v0), 32'd0);
      chk({tag, " busy"}, 32'(busy0), 32'd0);
      chk({tag, " done"}, 32'(done0), 32'd0);
      chk({tag, " halt_pc"}, 32'(halt0), 32'd0);
      chk({tag, " dut1 valid"}, 32'(v1), 32'd0);
   endtask

   task automatic load_prog(input vec_t v);
      int base;
      base = v.sel ? 1022 : 0;
      for (int i = 0; i < MEM_N; i++) mem[i] = $urandom | 32'h1;
      for (int i = 0; i < v.len; i++) mem[(base + i) % MEM_N] = $urandom | 32'h1;
      if (v.fixed) begin
         mem[0] = 32'h0300_2080;
         mem[1] = 32'h0400_0810;
      end
      mem[(base + v.len) % MEM_N] = 32'd0;
   endtask

   // Expected delivery order: walk memory from the start address until a zero word
   task automatic build_model(input int base);
      int p;
      int n;
      p = base;
      n = 0;
      exp_instr.delete();
      exp_pc.delete();
      while (mem[p] != 32'd0 && n < MEM_N) begin
         exp_instr.push_back(mem[p]);
         exp_pc.push_back(p);
         p = (p + 1) % MEM_N;
         n++;
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int            got, first, done_lat, stalls, first_hs, last_hs;
      logic          prev_stall;
      logic [IW-1:0] prev_i;
      logic [AW-1:0] prev_p, la;
      load_prog(v);
      build_model(v.sel ? 1022 : 0);
      sel = v.sel;
      got = 0; first = -1; done_lat = -1; stalls = 0; first_hs = -1; last_hs = -1;
      prev_stall = 1'b0; prev_i = '0; prev_p = '0;
      @(posedge clk); #1;
      if (v.sel) start1 = 1'b1; else start0 = 1'b1;
      ready = 1'b1;
      for (int k = 0; k < 300 && done_lat < 0; k++) begin
         @(posedge clk); #1;
         start0 = 1'b0;
         start1 = 1'b0;
         if (v.xstart && k == 1) begin
            if (v.sel) start1 = 1'b1; else start0 = 1'b1;
         end
         if (m_valid && first < 0) first = k;
         case (v.mode)
            0:       ready = 1'b1;
            1:       ready = !(first >= 0 && k - first < 5);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         if (prev_stall) begin
            chk({tag, " hold valid"}, 32'(m_valid), 32'd1);
            chk({tag, " hold instr"}, m_out, prev_i);
            chk({tag, " hold pc"}, 32'(m_pc), 32'(prev_p));
         end
         if (m_valid) begin
            la = m_addr - m_pc;
            checks++;
            if (la > 10'd2) begin
               errors++;
               $display("FAIL %s lookahead: addr %0d head pc %0d, distance must be <= 2", tag, m_addr, m_pc);
            end
            if (ready) begin
               if (exp_pc.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL %s extra instr: got 0x%08h pc %0d, expected none", tag, m_out, m_pc);
               end else begin
                  chk({tag, " instr"}, m_out, exp_instr.pop_front());
                  chk({tag, " pc"}, 32'(m_pc), 32'(exp_pc.pop_front()));
               end
               got++;
               if (first_hs < 0) first_hs = k;
               last_hs = k;
            end else begin
               stalls++;
            end
         end
         prev_stall = m_valid && !ready;
         prev_i     = m_out;
         prev_p     = m_pc;
         if (m_done) done_lat = k + 1;
      end
      if (done_lat < 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no done within 300 cycles, required a done pulse", tag);
      end
      chk({tag, " count"}, 32'(got), 32'(v.exp_n));
      chk({tag, " halt_pc"}, 32'(m_halt), 32'(v.exp_halt));
      chk({tag, " undelivered"}, 32'(exp_pc.size()), 32'd0);
      if (v.len > 0) begin
         chk({tag, " first latency"}, 32'(first + 1), 32'd3);
         if (v.mode == 0) chk({tag, " throughput span"}, 32'(last_hs - first_hs + 1), 32'(v.len));
      end else begin
         chk({tag, " no valid"}, 32'(first), 32'hFFFF_FFFF);
         checks++;
         if (done_lat > 4) begin
            errors++;
            $display("FAIL %s done latency: got %0d cycles, required <= 4", tag, done_lat);
         end
      end
`ifdef IFU_PERF_CNT_EN
      chk({tag, " perf_fetched"}, m_pf, 32'(got));
      chk({tag, " perf_stall"}, m_ps, 32'(stalls));
`endif
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " busy after"}, 32'(m_busy), 32'd0);
      chk({tag, " done pulse"}, 32'(m_done), 32'd0);
   endtask

   vec_t vecs [6];
   vec_t rv;

   initial begin
      vecs[0] = '{sel:1'b0, len:2, mode:0, fixed:1'b1, xstart:1'b0, exp_n:2, exp_halt:2};
      vecs[1] = '{sel:1'b0, len:2, mode:1, fixed:1'b1, xstart:1'b0, exp_n:2, exp_halt:2};
      vecs[2] = '{sel:1'b1, len:3, mode:0, fixed:1'b0, xstart:1'b0, exp_n:3, exp_halt:1};
      vecs[3] = '{sel:1'b0, len:0, mode:0, fixed:1'b0, xstart:1'b0, exp_n:0, exp_halt:0};
      vecs[4] = '{sel:1'b0, len:4, mode:0, fixed:1'b0, xstart:1'b1, exp_n:4, exp_halt:4};
      vecs[5] = '{sel:1'b0, len:6, mode:1, fixed:1'b0, xstart:1'b0, exp_n:6, exp_halt:6};

      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ready = 1'b0; sel = 1'b0;
      for (int i = 0; i < MEM_N; i++) mem[i] = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Reset while the FIFO holds two entries, then refetch from pc 0
      rv = '{sel:1'b0, len:10, mode:0, fixed:1'b0, xstart:1'b0, exp_n:10, exp_halt:10};
      load_prog(rv);
      sel = 1'b0;
      ready = 1'b0;
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("midrst pre valid", 32'(v0), 32'd1);
      chk("midrst pre lookahead", 32'(addr0 - pc0), 32'd2);
      chk("midrst pre busy", 32'(busy0), 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset("midrst");
      rst = 1'b0;
      run_vec("after_rst", vecs[0]);

      for (int r = 0; r < 8; r++) begin
         rv.sel      = 1'($urandom_range(0, 1));
         rv.len      = $urandom_range(0, 12);
         rv.mode     = 2;
         rv.fixed    = 1'b0;
         rv.xstart   = 1'($urandom_range(0, 1));
         rv.exp_n    = rv.len;
         rv.exp_halt = ((rv.sel ? 1022 : 0) + rv.len) % MEM_N;
         run_vec($sformatf("rand%0d", r), rv);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
